cpu_sram_bridge: RTL and testbench
==================================

Name: cpu_sram_bridge

Overview:
- Sits directly downstream of the CPU core, between its instruction/data SRAM-style ports and a single shared memory port that uses a request/ready handshake.
- The core assumes fixed-latency memory: en in cycle N, rdata valid in N+1. This block makes that assumption hold over a variable-latency memory by serialising instruction and data accesses.
- While a captured access is outstanding it drives stallreq to freeze the pipeline, and it holds the returned read data in registers.

Parameters:
ADDR_MASK, 32'h1FFF_FFFF, AND-mask applied to core addresses to form mem_addr (kseg0/kseg1 to physical).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
inst_sram_en  input  1  core instruction fetch request
inst_sram_wen  input  4  instruction write strobes; ignored, fetch is always a read
inst_sram_addr  input  32  fetch address
inst_sram_wdata  input  32  ignored
inst_sram_rdata  output  32  registered fetch data returned to core
data_sram_en  input  1  core data access request
data_sram_wen  input  4  byte write strobes; 0 means read
data_sram_addr  input  32  data address
data_sram_wdata  input  32  store data
data_sram_rdata  output  32  registered load data returned to core
stallreq  output  1  pipeline freeze request to CTRL
mem_req  output  1  memory request valid
mem_wr  output  1  1 = write, 0 = read
mem_wstrb  output  4  byte strobes (0 on reads)
mem_addr  output  32  physical address
mem_wdata  output  32  write data
mem_addr_ok  input  1  memory accepts request this cycle
mem_rdata  input  32  read data
mem_data_ok  input  1  response valid, for reads and writes

Behaviour:
- Reset: state IDLE; inst_sram_rdata = 0; data_sram_rdata = 0; mem_req = 0; mem_wr = 0; mem_wstrb = 0; mem_addr = 0; mem_wdata = 0; pending flags cleared.
  - Reset mid-transaction aborts it immediately.
  - The memory side shares the same rst, so no stale mem_data_ok can arrive after reset.
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
- IDLE:
  - If inst_sram_en or data_sram_en is high: latch both requests (en, wen, addr, wdata) into pending registers, and assert stallreq combinationally in that same cycle.
  - Go to D_REQ if data is pending, else I_REQ.
  - With no request: stallreq = 0, stay in IDLE.
- Ordering: data has priority over instruction (the data access is older in program order).
- D_REQ / I_REQ:
  - mem_req = 1; address, strobes and data are driven from the pending registers.
  - mem_addr = addr & ADDR_MASK.
  - mem_req, mem_wr, mem_wstrb, mem_addr and mem_wdata stay stable until mem_addr_ok. On the mem_addr_ok cycle, move to the matching *_WAIT state.
  - mem_req is deasserted in *_WAIT; only one transaction is outstanding at a time.
- D_WAIT / I_WAIT:
  - On mem_data_ok for a read, capture mem_rdata into the corresponding rdata register.
  - On mem_data_ok for a write, the rdata registers are unchanged.
  - After D_WAIT, go to I_REQ if an instruction is pending, else DONE. After I_WAIT, go to DONE.
- mem_data_ok arriving in the same cycle as mem_addr_ok is not legal from the memory; the bridge only samples mem_data_ok in *_WAIT.
- DONE:
  - stallreq = 0, so the core advances at the end of this cycle.
  - The core still shows the old request; the bridge ignores it.
  - Unconditionally return to IDLE, so the next cycle sees the core's new request.
- stallreq is 1 in IDLE-with-request, D_REQ, D_WAIT, I_REQ and I_WAIT; it is 0 in IDLE-without-request and in DONE.
- rdata registers hold their value until overwritten by a later read. The core therefore sees valid data in the cycle after DONE, matching 1-cycle SRAM semantics.
- Minimum latency, memory with addr_ok = 1 and data_ok one cycle later:
  - fetch only: 4 cycles IDLE through DONE;
  - fetch plus data: 6 cycles.

Test Plan:
- Fetch only, addr 0xBFC0_0000, addr_ok immediate, data_ok +1 with rdata 0x2408_0001 -> mem_addr = 0x1FC0_0000, stallreq high for 3 cycles, inst_sram_rdata = 0x2408_0001 in the cycle after DONE.
- Simultaneous load 0x8000_0010 and fetch 0xBFC0_0004 -> data request issued first (mem_wr = 0, addr 0x0000_0010), then fetch; each rdata register gets its own response; stallreq low exactly one cycle (DONE) before the next request.
- Store wen = 4'b0011, wdata 0xDEAD_BEEF alongside a fetch -> mem_wr = 1, mem_wstrb = 0011; data_sram_rdata keeps its prior value; fetch completes afterwards.
- addr_ok withheld 3 cycles, data_ok delayed 5 cycles -> mem_req and all address/data outputs stable while waiting, stallreq held high throughout, correct capture at the end.
- rst asserted while in D_WAIT -> next cycle state IDLE, mem_req = 0, both rdata registers = 0, stallreq = 0.
- DONE cycle with the core's request still asserted -> no new mem_req in DONE; a new transaction starts only from IDLE in the following cycle.

Source files
------------

// File: rtl/cpu_sram_bridge.sv
// cpu_sram_bridge: serialises core inst/data SRAM accesses onto one
// request/ready memory port, stalling the pipeline while one is in flight.
module cpu_sram_bridge #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic [31:0] mem_rdata,
    input  logic        mem_data_ok
);

    typedef enum logic [2:0] {
        IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE
    } state_t;

    state_t      state;
    logic        i_pend;
    logic [31:0] i_addr;

    // fetches never write; these inputs exist only for port symmetry
    logic unused_inst;
    assign unused_inst = ^{inst_sram_wen, inst_sram_wdata};

    // freeze the core from the request cycle until DONE
    assign stallreq = (state == IDLE) ? (inst_sram_en | data_sram_en)
                                      : (state != DONE);

    // sequencer: data access first (older), then the pending fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            i_pend          <= 1'b0;
            i_addr          <= 32'h0;
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_wstrb       <= 4'h0;
            mem_addr        <= 32'h0;
            mem_wdata       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    i_pend <= inst_sram_en;
                    i_addr <= inst_sram_addr;
                    if (data_sram_en) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= |data_sram_wen;
                        mem_wstrb <= data_sram_wen;
                        mem_addr  <= data_sram_addr & ADDR_MASK;
                        mem_wdata <= data_sram_wdata;
                        state     <= D_REQ;
                    end else if (inst_sram_en) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_wstrb <= 4'h0;
                        mem_addr  <= inst_sram_addr & ADDR_MASK;
                        mem_wdata <= 32'h0;
                        state     <= I_REQ;
                    end
                end
                D_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (mem_data_ok) begin
                        if (!mem_wr) data_sram_rdata <= mem_rdata;
                        if (i_pend) begin
                            mem_req   <= 1'b1;
                            mem_wr    <= 1'b0;
                            mem_wstrb <= 4'h0;
                            mem_addr  <= i_addr & ADDR_MASK;
                            mem_wdata <= 32'h0;
                            state     <= I_REQ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                I_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (mem_data_ok) begin
                        inst_sram_rdata <= mem_rdata;
                        i_pend          <= 1'b0;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    i_pend <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// tb_cpu_sram_bridge: directed cycle-by-cycle checks of the bridge
// sequencing, stalls, captures and reset abort.
module tb_cpu_sram_bridge;

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic [31:0] mem_rdata;
    logic        mem_data_ok;

    int compared = 0;
    int mismatched = 0;

    cpu_sram_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .mem_req         (mem_req),
        .mem_wr          (mem_wr),
        .mem_wstrb       (mem_wstrb),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_addr_ok     (mem_addr_ok),
        .mem_rdata       (mem_rdata),
        .mem_data_ok     (mem_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        inst_sram_en = 1'b0;
        inst_sram_wen = 4'h0;
        inst_sram_addr = 32'h0;
        inst_sram_wdata = 32'h0;
        data_sram_en = 1'b0;
        data_sram_wen = 4'h0;
        data_sram_addr = 32'h0;
        data_sram_wdata = 32'h0;
        mem_addr_ok = 1'b0;
        mem_rdata = 32'h0;
        mem_data_ok = 1'b0;

        nxt();
        nxt();
        #1;
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_wr", {31'h0, mem_wr}, 32'h0);
        check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_irdata", inst_sram_rdata, 32'h0);
        check("rst_drdata", data_sram_rdata, 32'h0);
        check("rst_stall", {31'h0, stallreq}, 32'h0);

        // fetch only: IDLE, I_REQ, I_WAIT, DONE
        nxt();
        rst = 1'b0;
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'hBFC0_0000;
        mem_addr_ok = 1'b1;
        #1;
        check("f_idle_stall", {31'h0, stallreq}, 32'h1);
        check("f_idle_req", {31'h0, mem_req}, 32'h0);
        nxt();
        #1;
        check("f_ireq_req", {31'h0, mem_req}, 32'h1);
        check("f_ireq_addr", mem_addr, 32'h1FC0_0000);
        check("f_ireq_wr", {31'h0, mem_wr}, 32'h0);
        check("f_ireq_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h2408_0001;
        #1;
        check("f_iwait_req", {31'h0, mem_req}, 32'h0);
        check("f_iwait_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        mem_data_ok = 1'b0;
        mem_rdata = 32'h0;
        #1;
        check("f_done_stall", {31'h0, stallreq}, 32'h0);
        check("f_done_req", {31'h0, mem_req}, 32'h0);
        nxt();
        inst_sram_en = 1'b0;
        #1;
        check("f_after_rdata", inst_sram_rdata, 32'h2408_0001);
        check("f_after_stall", {31'h0, stallreq}, 32'h0);

        // load plus fetch: data goes first
        nxt();
        data_sram_en = 1'b1;
        data_sram_wen = 4'h0;
        data_sram_addr = 32'h8000_0010;
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'hBFC0_0004;
        #1;
        check("lf_idle_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        #1;
        check("lf_dreq_req", {31'h0, mem_req}, 32'h1);
        check("lf_dreq_wr", {31'h0, mem_wr}, 32'h0);
        check("lf_dreq_addr", mem_addr, 32'h0000_0010);
        check("lf_dreq_wstrb", {28'h0, mem_wstrb}, 32'h0);
        nxt();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h1111_2222;
        #1;
        check("lf_dwait_req", {31'h0, mem_req}, 32'h0);
        check("lf_dwait_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        mem_data_ok = 1'b0;
        #1;
        check("lf_ireq_req", {31'h0, mem_req}, 32'h1);
        check("lf_ireq_addr", mem_addr, 32'h1FC0_0004);
        check("lf_ireq_drdata", data_sram_rdata, 32'h1111_2222);
        check("lf_ireq_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h3333_4444;
        #1;
        nxt();
        mem_data_ok = 1'b0;
        #1;
        check("lf_done_stall", {31'h0, stallreq}, 32'h0);
        check("lf_done_req", {31'h0, mem_req}, 32'h0);
        check("lf_done_irdata", inst_sram_rdata, 32'h3333_4444);
        check("lf_done_drdata", data_sram_rdata, 32'h1111_2222);

        // store plus fetch, presented straight after DONE
        nxt();
        data_sram_wen = 4'b0011;
        data_sram_addr = 32'h8000_0020;
        data_sram_wdata = 32'hDEAD_BEEF;
        inst_sram_addr = 32'hBFC0_0008;
        #1;
        check("sf_idle_req", {31'h0, mem_req}, 32'h0);
        check("sf_idle_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        #1;
        check("sf_dreq_req", {31'h0, mem_req}, 32'h1);
        check("sf_dreq_wr", {31'h0, mem_wr}, 32'h1);
        check("sf_dreq_wstrb", {28'h0, mem_wstrb}, 32'h3);
        check("sf_dreq_addr", mem_addr, 32'h0000_0020);
        check("sf_dreq_wdata", mem_wdata, 32'hDEAD_BEEF);
        nxt();
        mem_data_ok = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        nxt();
        mem_data_ok = 1'b0;
        #1;
        check("sf_ireq_drdata", data_sram_rdata, 32'h1111_2222);
        check("sf_ireq_addr", mem_addr, 32'h1FC0_0008);
        check("sf_ireq_wr", {31'h0, mem_wr}, 32'h0);
        check("sf_ireq_wstrb", {28'h0, mem_wstrb}, 32'h0);
        nxt();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h5555_6666;
        #1;
        nxt();
        mem_data_ok = 1'b0;
        #1;
        check("sf_done_stall", {31'h0, stallreq}, 32'h0);
        check("sf_done_irdata", inst_sram_rdata, 32'h5555_6666);
        check("sf_done_drdata", data_sram_rdata, 32'h1111_2222);
        nxt();
        data_sram_en = 1'b0;
        data_sram_wen = 4'h0;
        inst_sram_en = 1'b0;
        #1;
        check("sf_idle2_stall", {31'h0, stallreq}, 32'h0);

        // slow memory: addr_ok withheld 3 cycles, data_ok after 5
        nxt();
        data_sram_en = 1'b1;
        data_sram_addr = 32'hA000_1000;
        data_sram_wdata = 32'h1234_5678;
        mem_addr_ok = 1'b0;
        #1;
        check("sl_idle_stall", {31'h0, stallreq}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            nxt();
            data_sram_addr = 32'h0;
            data_sram_wdata = 32'h0;
            #1;
            check("sl_hold_req", {31'h0, mem_req}, 32'h1);
            check("sl_hold_addr", mem_addr, 32'h0000_1000);
            check("sl_hold_wdata", mem_wdata, 32'h1234_5678);
            check("sl_hold_wr", {31'h0, mem_wr}, 32'h0);
            check("sl_hold_stall", {31'h0, stallreq}, 32'h1);
        end
        nxt();
        mem_addr_ok = 1'b1;
        #1;
        check("sl_accept_req", {31'h0, mem_req}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            nxt();
            #1;
            check("sl_wait_req", {31'h0, mem_req}, 32'h0);
            check("sl_wait_stall", {31'h0, stallreq}, 32'h1);
        end
        nxt();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h7777_8888;
        #1;
        check("sl_last_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        mem_data_ok = 1'b0;
        #1;
        check("sl_done_stall", {31'h0, stallreq}, 32'h0);
        check("sl_done_drdata", data_sram_rdata, 32'h7777_8888);
        check("sl_done_irdata", inst_sram_rdata, 32'h5555_6666);
        nxt();
        data_sram_en = 1'b0;
        #1;

        // reset while in D_WAIT
        nxt();
        data_sram_en = 1'b1;
        data_sram_addr = 32'h8000_0040;
        #1;
        nxt();
        #1;
        check("rw_dreq_req", {31'h0, mem_req}, 32'h1);
        nxt();
        rst = 1'b1;
        #1;
        check("rw_dwait_stall", {31'h0, stallreq}, 32'h1);
        nxt();
        rst = 1'b0;
        data_sram_en = 1'b0;
        #1;
        check("rw_req", {31'h0, mem_req}, 32'h0);
        check("rw_stall", {31'h0, stallreq}, 32'h0);
        check("rw_irdata", inst_sram_rdata, 32'h0);
        check("rw_drdata", data_sram_rdata, 32'h0);
        check("rw_addr", mem_addr, 32'h0);
        nxt();
        #1;
        check("rw_idle_req", {31'h0, mem_req}, 32'h0);
        check("rw_idle_stall", {31'h0, stallreq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
